w0rm_core_fetch: RTL and testbench
==================================

// Module: w0rm_core_fetch
// PURPOSE
//  Instruction fetch front end; owns the architectural PC and consumes the branch unit's redirect (next_pc/next_pc_valid/flush).
//  Issues in-order 16-bit instruction reads to instruction memory and buffers responses in a FIFO_DEPTH-entry queue.
//  Presents {inst, pc} to decode over a valid/ready handshake. On redirect, squashes queued and in-flight fetches.
// PARAMETERS
//  ADDR_WIDTH  32  PC / memory address width in bits
//  INST_WIDTH  16  instruction word width in bits; PC step is 2 bytes
//  RESET_PC    0   PC value loaded on reset; bit 0 is forced to 0
//  FIFO_DEPTH  2   response queue entries; power of two, >=2; also caps outstanding requests
// PORTS
//  clk               in   1           rising-edge clock
//  reset             in   1           asynchronous, active-high reset
//  redirect_valid    in   1           branch unit next_pc_valid; one-cycle pulse
//  redirect_pc       in   ADDR_WIDTH  branch target; sampled when redirect_valid=1
//  imem_req_valid    out  1           read request valid
//  imem_req_ready    in   1           memory accepts request when valid&ready
//  imem_req_addr     out  ADDR_WIDTH  read address (== current PC)
//  imem_resp_valid   in   1           read data valid; responses are in order, latency >=1
//  imem_resp_data    in   INST_WIDTH  instruction word
//  decode_valid      out  1           {decode_inst, decode_pc} valid
//  decode_ready      in   1           decode consumes entry when valid&ready
//  decode_inst       out  INST_WIDTH  instruction at head of queue
//  decode_pc         out  ADDR_WIDTH  address that instruction was fetched from
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC&~1, queue empty, outstanding=0, drop=0;
//   outputs: imem_req_valid=0, imem_req_addr=RESET_PC&~1, decode_valid=0, decode_inst=0, decode_pc=0.
//  Counters: outstanding = accepted requests not yet answered; drop = responses still to be discarded.
//  Issue: imem_req_valid=1 iff !redirect_valid && (outstanding + queue_count) < FIFO_DEPTH. Combinational.
//   This guarantees every response has a queue slot; no backpressure exists on the response side.
//  Request accepted (valid&ready): pc <= pc+2 mod 2^ADDR_WIDTH (wraps to 0); outstanding++.
//   A per-request pc tag FIFO (depth FIFO_DEPTH) records the address for decode_pc.
//  Response (imem_resp_valid): outstanding--. If drop>0: drop--, data discarded. Else push {data, tag} to the queue.
//  Decode: decode_valid = queue non-empty && !redirect_valid; head popped on decode_valid&decode_ready.
//   Push and pop in the same cycle are allowed at full and at empty (no bubble when full; an empty queue shows data
//   the cycle after the push, i.e. fetch-to-decode latency = memory latency + 1 cycle).
//  Redirect (redirect_valid=1), applied on that edge and taking priority over everything else:
//   pc <= redirect_pc & ~1 (odd targets are silently aligned); queue and tag FIFO cleared; no request issued this cycle;
//   drop <= outstanding minus any response arriving in the same cycle. Pending pops are cancelled
//   (decode_valid is low during the redirect cycle).
//   First request to the new pc issues on the next cycle; old-path responses arriving later are dropped via drop.
//  Back-to-back redirects: the later one wins; drop accumulates correctly (no response lost or double counted).
//  imem_resp_valid with outstanding==0 is a protocol error; it is ignored and does not change state.
//  Reset mid-operation: all state returns to reset values immediately; in-flight memory responses after reset are
//   ignored because outstanding==0.
// TESTING
//  1 Reset, imem ready=1, latency 1, decode_ready=1 -> req addrs 0,2,4,...; decode_pc 0,2,4 with inst matching the model.
//  2 decode_ready=0 for 10 cycles -> at most FIFO_DEPTH requests issue, queue full, no loss; release -> in-order drain.
//  3 Redirect to 0x100 with 2 outstanding (latency 3) -> both old responses dropped, next decode_pc=0x100.
//  4 Redirect to 0x201 on the same cycle as a response and a pop -> response dropped, no pop, next req addr=0x200.
//  5 ADDR_WIDTH=8, RESET_PC=0xFC -> req addrs 0xFC,0xFE,0x00; decode_pc follows the wrap.
//  6 Assert reset with queue full and 1 outstanding -> outputs hit reset values at once; late response ignored;
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/w0rm_core_fetch.sv
// Instruction fetch front end: owns the PC, issues in-order imem reads and queues
// responses for decode, squashing everything still in flight on a branch redirect.
module w0rm_core_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   output logic                  decode_valid,
   input  logic                  decode_ready,
   output logic [INST_WIDTH-1:0] decode_inst,
   output logic [ADDR_WIDTH-1:0] decode_pc
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(1));
   localparam logic [ADDR_WIDTH-1:0] START_PC   = RESET_PC & ALIGN_MASK;
   localparam logic [CW:0]           DEPTH_W    = (CW + 1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         drop_q, drop_d;
   logic [CW-1:0]         q_count_q, q_count_d;
   logic [PW-1:0]         q_head_q, q_head_d;
   logic [PW-1:0]         q_tail_q, q_tail_d;
   logic [PW-1:0]         tag_head_q, tag_head_d;
   logic [PW-1:0]         tag_tail_q, tag_tail_d;

   logic [INST_WIDTH-1:0] q_inst_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] q_pc_mem   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] tag_mem    [FIFO_DEPTH];

   logic resp_fire;
   logic req_fire;
   logic pop;
   logic push;
   logic q_empty;

   // Issue only while every possible response is guaranteed a queue slot.
   assign imem_req_valid = !reset && !redirect_valid &&
                           (({1'b0, outstanding_q} + {1'b0, q_count_q}) < DEPTH_W);
   assign imem_req_addr  = pc_q;

   assign q_empty      = (q_count_q == '0);
   assign decode_valid = !reset && !q_empty && !redirect_valid;
   assign decode_inst  = q_empty ? '0 : q_inst_mem[q_head_q];
   assign decode_pc    = q_empty ? '0 : q_pc_mem[q_head_q];

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_fire = imem_resp_valid && (outstanding_q != '0);
   assign req_fire  = imem_req_valid && imem_req_ready;
   assign pop       = decode_valid && decode_ready;
   assign push      = resp_fire && (drop_q == '0) && !redirect_valid;

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      q_count_d     = q_count_q;
      q_head_d      = q_head_q;
      q_tail_d      = q_tail_q;
      tag_head_d    = tag_head_q;
      tag_tail_d    = tag_tail_q;
      if (redirect_valid) begin
         pc_d          = redirect_pc & ALIGN_MASK;
         outstanding_d = outstanding_q - CW'(resp_fire);
         drop_d        = outstanding_q - CW'(resp_fire);
         q_count_d     = '0;
         q_head_d      = '0;
         q_tail_d      = '0;
         tag_head_d    = '0;
         tag_tail_d    = '0;
      end else begin
         if (req_fire) begin
            pc_d       = pc_q + ADDR_WIDTH'(2);
            tag_tail_d = tag_tail_q + PW'(1);
         end
         outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
         if (resp_fire) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               tag_head_d = tag_head_q + PW'(1);
               q_tail_d   = q_tail_q + PW'(1);
            end
         end
         if (pop) begin
            q_head_d = q_head_q + PW'(1);
         end
         q_count_d = q_count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= START_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
         q_count_q     <= '0;
         q_head_q      <= '0;
         q_tail_q      <= '0;
         tag_head_q    <= '0;
         tag_tail_q    <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         q_count_q     <= q_count_d;
         q_head_q      <= q_head_d;
         q_tail_q      <= q_tail_d;
         tag_head_q    <= tag_head_d;
         tag_tail_q    <= tag_tail_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted as valid.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         tag_mem[tag_tail_q] <= pc_q;
      end
      if (push) begin
         q_inst_mem[q_tail_q] <= imem_resp_data;
         q_pc_mem[q_tail_q]   <= tag_mem[tag_head_q];
      end
   end

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Randomized scoreboard bench for w0rm_core_fetch: a 32-bit depth-4 instance under random
// traffic/redirects/reset, and an 8-bit depth-2 instance that exercises PC wrap.
module tb_w0rm_core_fetch;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] inst;
   } ent_t;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [15:0] imem_resp_data = '0;
   logic        decode_valid;
   logic        decode_ready = 1'b0;
   logic [15:0] decode_inst;
   logic [31:0] decode_pc;

   logic        w_redirect_valid = 1'b0;
   logic [7:0]  w_redirect_pc = '0;
   logic        w_req_valid;
   logic        w_req_ready = 1'b1;
   logic [7:0]  w_req_addr;
   logic        w_resp_valid = 1'b0;
   logic [15:0] w_resp_data = '0;
   logic        w_decode_valid;
   logic        w_decode_ready = 1'b1;
   logic [15:0] w_decode_inst;
   logic [7:0]  w_decode_pc;

   w0rm_core_fetch #(
      .ADDR_WIDTH(32), .INST_WIDTH(16), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .decode_valid(decode_valid), .decode_ready(decode_ready),
      .decode_inst(decode_inst), .decode_pc(decode_pc)
   );

   w0rm_core_fetch #(
      .ADDR_WIDTH(8), .INST_WIDTH(16), .RESET_PC(8'hFD), .FIFO_DEPTH(2)
   ) dut_w (
      .clk(clk), .reset(reset),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
      .imem_req_addr(w_req_addr),
      .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
      .decode_valid(w_decode_valid), .decode_ready(w_decode_ready),
      .decode_inst(w_decode_inst), .decode_pc(w_decode_pc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_dec = 0;
   int w_dec = 0;
   int cyc = 0;

   // Reference model state: memory in flight, and the decode stream still owed.
   mreq_t       mem_q[$];
   ent_t        exp_q[$];
   int          arrived = 0;
   logic [31:0] model_pc = 32'h0;
   mreq_t       w_mem_q[$];
   ent_t        w_exp_q[$];
   int          w_arrived = 0;
   logic [7:0]  w_pc = 8'hFC;

   int          lat_min = 1, lat_max = 1, rdy_p = 100, dr_p = 100, redir_p = 0;
   bit          force_redir = 0;
   logic [31:0] force_pc = '0;
   bit          spurious = 0;

   function automatic logic [15:0] hash(input logic [31:0] a);
      logic [15:0] lo;
      lo = a[15:0];
      return (lo * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard: evaluates the transaction the coming rising edge will perform.
   always @(negedge clk) begin
      mreq_t m;
      ent_t  e;
      if (reset) begin
         chk("rst_req_valid", imem_req_valid, 1'b0);
         chk("rst_req_addr", imem_req_addr, 32'h0);
         chk("rst_decode_valid", decode_valid, 1'b0);
         chk("rst_decode_inst", decode_inst, 16'h0);
         chk("rst_decode_pc", decode_pc, 32'h0);
         chk("w_rst_req_addr", w_req_addr, 8'hFC);
         mem_q.delete(); exp_q.delete(); arrived = 0; model_pc = 32'h0;
         w_mem_q.delete(); w_exp_q.delete(); w_arrived = 0; w_pc = 8'hFC;
      end else begin
         chk("req_valid", imem_req_valid,
             !redirect_valid && ((mem_q.size() + arrived) < DEPTH));
         chk("decode_valid", decode_valid, !redirect_valid && (arrived > 0));
         if (decode_valid && decode_ready) begin
            if (arrived == 0 || exp_q.size() == 0) begin
               chk("decode_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               arrived--;
               n_dec++;
               $display("decode pc=%08h inst=%04h (exp pc=%08h inst=%04h)",
                        decode_pc, decode_inst, e.pc, e.inst);
               chk("decode_pc", decode_pc, e.pc);
               chk("decode_inst", decode_inst, e.inst);
            end
         end
         if (imem_resp_valid && mem_q.size() > 0) begin
            m = mem_q.pop_front();
            if (m.live) arrived++;
         end
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_pc);
            mem_q.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min)), 1'b1});
            exp_q.push_back('{model_pc, hash(model_pc)});
            model_pc = model_pc + 32'd2;
         end
         if (redirect_valid) begin
            exp_q.delete();
            arrived = 0;
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            model_pc = redirect_pc & 32'hFFFF_FFFE;
         end

         chk("w_req_valid", w_req_valid, (w_mem_q.size() + w_arrived) < 2);
         chk("w_decode_valid", w_decode_valid, w_arrived > 0);
         if (w_decode_valid) begin
            if (w_arrived == 0 || w_exp_q.size() == 0) begin
               chk("w_decode_unexpected", 1'b1, 1'b0);
            end else begin
               e = w_exp_q.pop_front();
               w_arrived--;
               w_dec++;
               $display("w_decode pc=%02h inst=%04h (exp pc=%02h inst=%04h)",
                        w_decode_pc, w_decode_inst, e.pc[7:0], e.inst);
               chk("w_decode_pc", w_decode_pc, e.pc[7:0]);
               chk("w_decode_inst", w_decode_inst, e.inst);
            end
         end
         if (w_resp_valid && w_mem_q.size() > 0) begin
            m = w_mem_q.pop_front();
            w_arrived++;
         end
         if (w_req_valid) begin
            chk("w_req_addr", w_req_addr, w_pc);
            w_mem_q.push_back('{{24'h0, w_req_addr}, cyc + 1, 1'b1});
            w_exp_q.push_back('{{24'h0, w_pc}, hash({24'h0, w_pc})});
            w_pc = w_pc + 8'd2;
         end
      end
   end

   task automatic drive();
      if (reset) begin
         redirect_valid = 0; imem_req_ready = 0; imem_resp_valid = 0; decode_ready = 0;
         w_resp_valid = 0;
         return;
      end
      imem_req_ready = spurious ? 1'b0 : ($urandom_range(99) < rdy_p);
      decode_ready   = ($urandom_range(99) < dr_p);
      redirect_valid = force_redir || ($urandom_range(99) < redir_p);
      redirect_pc    = force_redir ? force_pc : $urandom;
      if (spurious) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 16'hDEAD;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = hash(mem_q[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 16'($urandom);
      end
      w_resp_valid = (w_mem_q.size() > 0 && w_mem_q[0].due <= cyc);
      w_resp_data  = w_resp_valid ? hash(w_mem_q[0].addr) : 16'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      bit done;
      drive();
      repeat (3) step();
      @(posedge clk); #1; reset = 1'b0; drive();

      // Streaming, latency 1, always ready.
      repeat (40) step();

      // Decode stalls: issue must cap at DEPTH, then drain in order.
      dr_p = 0;   repeat (10) step();
      dr_p = 100; repeat (10) step();

      // Redirect to 0x100 with old requests still in flight.
      lat_min = 3; lat_max = 3; done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk); #1;
         if (mem_q.size() >= 2) begin force_redir = 1; force_pc = 32'h100; done = 1; end
         drive();
         force_redir = 0;
      end
      if (!done) chk("redirect_0x100_timeout", 1'b0, 1'b1);
      repeat (20) step();

      // Odd redirect target coinciding with a response and a pending pop.
      lat_min = 1; lat_max = 2; done = 0;
      for (int i = 0; i < 80 && !done; i++) begin
         @(posedge clk); #1;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && mem_q[0].live && arrived > 0) begin
            force_redir = 1; force_pc = 32'h201; done = 1;
         end
         drive();
         force_redir = 0;
      end
      if (!done) chk("redirect_0x201_timeout", 1'b0, 1'b1);
      repeat (20) step();

      // Random traffic with redirects, including back-to-back ones.
      lat_min = 1; lat_max = 4; rdy_p = 70; dr_p = 70; redir_p = 6;
      repeat (600) step();

      // Reset with entries queued and a request outstanding.
      redir_p = 0; rdy_p = 100; dr_p = 0; lat_min = 3; lat_max = 3; done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk); #1;
         if (arrived >= 2 && mem_q.size() >= 1) begin
            reset = 1'b1; done = 1;
         end
         drive();
      end
      if (!done) chk("reset_setup_timeout", 1'b0, 1'b1);
      step();
      @(posedge clk); #1; reset = 1'b0; spurious = 1; drive(); spurious = 0;
      dr_p = 100; lat_min = 1; lat_max = 2;
      repeat (60) step();

      chk("progress_main", n_dec > 200, 1'b1);
      chk("progress_wrap", w_dec > 200, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
